main_mem_arbiter: RTL and testbench
===================================

# main_mem_arbiter

Round-robin Wishbone arbiter that shares the single main-memory slave port between `N_MASTERS` bus masters (core, Ethernet DMA, boot/test loader). It sits directly in front of the main memory model/controller and owns the slave's `cyc`/`stb` for the whole transfer. It holds a grant for as long as the master keeps `cyc` high, supporting multi-beat transfers. A watchdog converts a hung slave into a Wishbone error to the owning master.

## Interface
Parameters:
- `N_MASTERS`, 3: number of requesting masters, 2..8.
- `WB_DWIDTH`, 32: data width, 32 or 128.
- `WB_SWIDTH`, 4: byte-select width, `WB_DWIDTH/8`.
- `TIMEOUT`, 255: cycles `stb` may wait for ack before error; 1..65535.

Ports. Master-side buses are packed; master k occupies slice k.
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_m_adr` in 32·N: master addresses.
- `i_m_sel` in SWIDTH·N: master byte selects.
- `i_m_we` in N: master write enables.
- `i_m_dat` in DWIDTH·N: master write data.
- `i_m_cyc` in N: master cycle signals.
- `i_m_stb` in N: master strobes.
- `o_m_dat` out DWIDTH·N: slave read data, broadcast to all slices.
- `o_m_ack` out N: per-master ack, at most one bit high.
- `o_m_err` out N: per-master err, at most one bit high.
- `o_s_adr` out 32: address to memory.
- `o_s_sel` out SWIDTH: byte selects to memory.
- `o_s_we` out 1: write enable to memory.
- `o_s_dat` out DWIDTH: write data to memory.
- `o_s_cyc` out 1: cycle to memory.
- `o_s_stb` out 1: strobe to memory.
- `i_s_dat` in DWIDTH: read data from memory.
- `i_s_ack` in 1: ack from memory.
- `i_s_err` in 1: err from memory.
- `o_grant` out N: one-hot current owner, 0 when idle. Used for debug and performance counters.

## Operation
- States:
  - IDLE: no owner, slave `cyc`/`stb` low.
  - GRANT: owner `g` is routed to the slave.
  - ERR: watchdog fired; slave is blocked.
- IDLE, with any `i_m_cyc[k] & i_m_stb[k]`:
  - Pick the first requester scanning from `ptr` upward, modulo N.
  - Register `g` and go to GRANT.
  - Set `ptr` to `g+1` mod N.
  - After reset, `ptr` = 0, so master 0 wins first.
- GRANT routing:
  - Master g's `adr`/`sel`/`we`/`dat` drive the slave combinationally.
  - `o_s_cyc` = `i_m_cyc[g]`.
  - `o_s_stb` = `i_m_stb[g] & i_m_cyc[g]`.
  - `o_m_ack[g]` = `i_s_ack`; `o_m_err[g]` = `i_s_err`. All other ack/err bits are 0.
- Leaving GRANT:
  - `i_m_cyc[g]` low: go to IDLE.
  - Multiple stb/ack beats within one `cyc` stay granted. Other masters are held off, with no preemption.
- Watchdog:
  - A counter increments each GRANT cycle with `o_s_stb` high and `i_s_ack`/`i_s_err` low. It clears otherwise.
  - Reaching `TIMEOUT`: pulse `o_m_err[g]` for one cycle and go to ERR.
  - ERR forces slave `cyc`/`stb` low and returns to IDLE when `i_m_cyc[g]` drops.
- Unrequested masters see ack = err = 0. Their writes never reach memory.

## Timing
- Reset values: state IDLE, `ptr` 0, counter 0, `o_grant` 0, all `o_s_cyc`/`o_s_stb`/`o_s_we`/`o_m_ack`/`o_m_err` 0.
- Grant latency: a request seen in IDLE at edge n reaches the slave in cycle n+1. A write to main memory is acked in cycle n+1. A read is acked 2 cycles after `stb` reaches the slave.
- One mandatory IDLE cycle separates consecutive grants, even to a different master.
- Simultaneous:
  - `i_s_ack` and timeout in the same cycle: ack wins and the counter clears.
  - `i_s_err` forwards like ack and clears the counter.
- A master dropping `stb` but keeping `cyc` keeps the grant; the counter is held at 0.
- Reset mid-transfer: slave `cyc`/`stb` are low in the cycle after the reset edge. An in-flight slave ack is not forwarded.

## Structure
- Shared package `main_mem_arb_pkg` holds:
  - State encoding (IDLE/GRANT/ERR).
  - `MAX_MASTERS` = 8.
  - `clog2` function for the `g`/`ptr` width.
- One sub-module, `rr_pick`, is purely combinational:
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot winner, its index, and a valid flag.

## Test plan
- Master 1 alone reads 0x0000_0100 holding 0xDEADBEEF: `o_grant` = 3'b010 one cycle after request. `o_m_ack[1]` fires 2 cycles after `o_s_stb` with data 0xDEADBEEF. `o_m_ack[0]` and `o_m_ack[2]` stay 0.
- All three masters request writes continuously from reset: grant order is 0,1,2,0,1,2. Each grant is separated by exactly one IDLE cycle. Each master's data lands at its own address.
- Master 0 holds `cyc` for a 4-beat read burst while master 2 requests: master 2 is granted only after master 0 drops `cyc`. All 4 beats return in order.
- Slave ack tied low, `TIMEOUT`=8, master 2 issues `stb`: `o_m_err[2]` pulses on the 8th wait cycle. The slave `stb` drops, and the arbiter returns to IDLE the cycle after `cyc` drops.
- `i_rst` asserted during a master-1 read, 1 cycle after `stb` reaches the slave: slave `cyc`/`stb` are 0 next cycle. No ack reaches master 1. Master 0 wins the first post-reset arbitration.
- `i_s_err` from the slave on a master-0 write: `o_m_err[0]` pulses the same cycle. The grant is held until `cyc` drops.

Source files
------------

// File: rtl/main_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// main_mem_arb_pkg
// Shared types and helpers for the main-memory Wishbone arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / GRANT / ERR)
//   MAX_MASTERS : upper bound on the number of requesting masters
//   ADR_W       : Wishbone address width
//   WD_W        : watchdog counter width (covers TIMEOUT up to 65535)
//   clog2()     : index width for owner / round-robin pointer registers
// ---------------------------------------------------------------------------
package main_mem_arb_pkg;

   localparam int unsigned MAX_MASTERS = 8;
   localparam int unsigned ADR_W       = 32;
   localparam int unsigned WD_W        = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ERR   = 2'd2
   } arb_state_e;

   // Smallest r with 2**r >= value; callers guarantee value >= 2.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/main_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or above ptr_i, wrapping modulo N.
//   req_i    : request vector, one bit per master
//   ptr_i    : highest-priority index for this arbitration (< N)
//   onehot_o : one-hot winner, zero when no request
//   idx_o    : binary index of the winner
//   valid_o  : at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import main_mem_arb_pkg::*;
#(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   // Scan N positions starting at ptr_i; the first hit wins.
   always_comb begin
      int unsigned pos;
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      pos      = 0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = 32'(ptr_i) + i;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!valid_o && req_i[pos]) begin
            valid_o       = 1'b1;
            onehot_o[pos] = 1'b1;
            idx_o         = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// ---------------------------------------------------------------------------
// main_mem_arbiter
// Round-robin Wishbone arbiter sharing the main-memory slave port between
// N_MASTERS masters. A grant is held while the owner keeps cyc high, so
// multi-beat transfers are never interleaved. A watchdog turns a slave that
// never answers into a one-cycle err to the owner and blocks the slave until
// the owner drops cyc.
// Ports (master buses are packed, master k occupies slice k):
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_m_adr/sel/we/dat/cyc/stb   : master requests
//   o_m_dat                      : slave read data broadcast to every slice
//   o_m_ack, o_m_err             : per-master responses, owner only
//   o_s_adr/sel/we/dat/cyc/stb   : request routed to main memory
//   i_s_dat, i_s_ack, i_s_err    : main-memory response
//   o_grant                      : one-hot owner, zero when idle
// ---------------------------------------------------------------------------
module main_mem_arbiter
   import main_mem_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS = 3,
   parameter int unsigned WB_DWIDTH = 32,
   parameter int unsigned WB_SWIDTH = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [ADR_W*N_MASTERS-1:0]     i_m_adr,
   input  logic [WB_SWIDTH*N_MASTERS-1:0] i_m_sel,
   input  logic [N_MASTERS-1:0]           i_m_we,
   input  logic [WB_DWIDTH*N_MASTERS-1:0] i_m_dat,
   input  logic [N_MASTERS-1:0]           i_m_cyc,
   input  logic [N_MASTERS-1:0]           i_m_stb,
   output logic [WB_DWIDTH*N_MASTERS-1:0] o_m_dat,
   output logic [N_MASTERS-1:0]           o_m_ack,
   output logic [N_MASTERS-1:0]           o_m_err,
   output logic [ADR_W-1:0]               o_s_adr,
   output logic [WB_SWIDTH-1:0]           o_s_sel,
   output logic                           o_s_we,
   output logic [WB_DWIDTH-1:0]           o_s_dat,
   output logic                           o_s_cyc,
   output logic                           o_s_stb,
   input  logic [WB_DWIDTH-1:0]           i_s_dat,
   input  logic                           i_s_ack,
   input  logic                           i_s_err,
   output logic [N_MASTERS-1:0]           o_grant
);

   localparam int unsigned IW = clog2(N_MASTERS);
   // Counter value seen on the TIMEOUT-th consecutive wait cycle.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   arb_state_e           state_q;
   logic [IW-1:0]        g_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        ptr_d;
   logic [N_MASTERS-1:0] grant_q;
   logic [WD_W-1:0]      wd_q;
   logic [WD_W-1:0]      wd_d;
   logic                 wd_wait;
   logic                 wd_fire;

   logic [N_MASTERS-1:0] req;
   logic [N_MASTERS-1:0] pick_onehot;
   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;
   logic                 own_cyc;
   logic                 own_stb;

   // Unpacked per-master views of the packed request buses.
   logic [ADR_W-1:0]     m_adr [N_MASTERS];
   logic [WB_SWIDTH-1:0] m_sel [N_MASTERS];
   logic [WB_DWIDTH-1:0] m_dat [N_MASTERS];

   for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
      assign m_adr[k] = i_m_adr[k*ADR_W +: ADR_W];
      assign m_sel[k] = i_m_sel[k*WB_SWIDTH +: WB_SWIDTH];
      assign m_dat[k] = i_m_dat[k*WB_DWIDTH +: WB_DWIDTH];
   end

   // A master requests only while both cyc and stb are high.
   assign req = i_m_cyc & i_m_stb;

   rr_pick #(
      .N (N_MASTERS)
   ) u_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   // Pointer moves one past the winner so it has lowest priority next time.
   assign ptr_d = (32'(pick_idx) == N_MASTERS - 1) ? '0 : pick_idx + IW'(1);

   assign own_cyc = i_m_cyc[g_q];
   assign own_stb = i_m_stb[g_q];
   assign o_m_dat = {N_MASTERS{i_s_dat}};
   assign o_grant = grant_q;

   // Slave request routing: only GRANT lets the owner's cyc/stb/we through.
   always_comb begin
      o_s_adr = m_adr[g_q];
      o_s_sel = m_sel[g_q];
      o_s_dat = m_dat[g_q];
      o_s_we  = 1'b0;
      o_s_cyc = 1'b0;
      o_s_stb = 1'b0;
      if (state_q == ST_GRANT) begin
         o_s_we  = i_m_we[g_q];
         o_s_cyc = own_cyc;
         o_s_stb = own_cyc & own_stb;
      end
   end

   // Response steering and watchdog; a real ack/err always beats a timeout.
   always_comb begin
      o_m_ack = '0;
      o_m_err = '0;
      wd_wait = 1'b0;
      wd_fire = 1'b0;
      wd_d    = '0;
      if (state_q == ST_GRANT) begin
         wd_wait      = o_s_stb & ~i_s_ack & ~i_s_err;
         wd_fire      = wd_wait & (wd_q == WD_LAST);
         o_m_ack[g_q] = i_s_ack;
         o_m_err[g_q] = i_s_err | wd_fire;
         if (wd_wait && !wd_fire) begin
            wd_d = wd_q + WD_W'(1);
         end
      end
   end

   // Arbiter FSM with registered owner, pointer and grant vector.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         wd_q    <= '0;
      end else begin
         wd_q <= wd_d;
         unique case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_q <= ST_GRANT;
                  g_q     <= pick_idx;
                  grant_q <= pick_onehot;
                  ptr_q   <= ptr_d;
               end
            end
            ST_GRANT: begin
               if (!own_cyc) begin
                  state_q <= ST_IDLE;
                  grant_q <= '0;
               end else if (wd_fire) begin
                  state_q <= ST_ERR;
               end
            end
            ST_ERR: begin
               if (!own_cyc) begin
                  state_q <= ST_IDLE;
                  grant_q <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_main_mem_arbiter
// Directed bench for main_mem_arbiter: three masters driven from one linear
// script, a small main-memory model (writes acked in the strobe cycle, reads
// acked two cycles after the strobe arrives) and hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_main_mem_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*32-1:0] m_adr;
   logic [N*SW-1:0] m_sel;
   logic [N-1:0]    m_we;
   logic [N*DW-1:0] m_dat;
   logic [N-1:0]    m_cyc;
   logic [N-1:0]    m_stb;
   logic [N*DW-1:0] m_rdat;
   logic [N-1:0]    m_ack;
   logic [N-1:0]    m_err;
   logic [31:0]     s_adr;
   logic [SW-1:0]   s_sel;
   logic            s_we;
   logic [DW-1:0]   s_wdat;
   logic            s_cyc;
   logic            s_stb;
   logic [DW-1:0]   s_rdat;
   logic            s_ack;
   logic            s_err;
   logic [N-1:0]    grant;

   logic ack_en;
   logic err_inj;
   logic force_ack;

   logic [31:0] mem [0:255];
   int          rd_cnt;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   main_mem_arbiter #(
      .N_MASTERS (N),
      .WB_DWIDTH (DW),
      .WB_SWIDTH (SW),
      .TIMEOUT   (TO)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_m_adr (m_adr),
      .i_m_sel (m_sel),
      .i_m_we  (m_we),
      .i_m_dat (m_dat),
      .i_m_cyc (m_cyc),
      .i_m_stb (m_stb),
      .o_m_dat (m_rdat),
      .o_m_ack (m_ack),
      .o_m_err (m_err),
      .o_s_adr (s_adr),
      .o_s_sel (s_sel),
      .o_s_we  (s_we),
      .o_s_dat (s_wdat),
      .o_s_cyc (s_cyc),
      .o_s_stb (s_stb),
      .i_s_dat (s_rdat),
      .i_s_ack (s_ack),
      .i_s_err (s_err),
      .o_grant (grant)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 'h40) return 32'hDEAD_BEEF;
      if (i >= 'hC0 && i < 'hC4) return 32'h1111_0000 + 32'(i - 'hC0);
      return 32'h0;
   endfunction

   function automatic logic [31:0] wadr(input int k, input int r);
      return 32'h200 + 32'((r * 3 + k) * 4);
   endfunction

   function automatic logic [31:0] wdat(input int k, input int r);
      return 32'hA000_0000 | 32'(r << 4) | 32'(k);
   endfunction

   // Main-memory model.
   assign s_ack  = (ack_en & s_cyc & s_stb & ~err_inj & (s_we | (rd_cnt == 2)))
                 | (force_ack & s_cyc & s_stb);
   assign s_err  = err_inj & s_cyc & s_stb;
   assign s_rdat = mem[s_adr[9:2]];

   always @(posedge clk) begin
      if (rst) begin
         rd_cnt <= 0;
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else begin
         if (s_cyc && s_stb && !s_we && !s_ack && !s_err) rd_cnt <= rd_cnt + 1;
         else                                              rd_cnt <= 0;
         if (s_cyc && s_stb && s_we && s_ack) begin
            for (int b = 0; b < SW; b++) begin
               if (s_sel[b]) mem[s_adr[9:2]][b*8 +: 8] <= s_wdat[b*8 +: 8];
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
      m_cyc[k]            = cyc;
      m_stb[k]            = stb;
      m_we[k]             = we;
      m_adr[k*32 +: 32]   = adr;
      m_dat[k*DW +: DW]   = dat;
      m_sel[k*SW +: SW]   = '1;
   endtask

   initial begin
      #50000;
      $display("FAIL tb_timeout: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      int k;
      int r;
      rst = 1'b1;
      m_adr = '0; m_sel = '0; m_we = '0; m_dat = '0; m_cyc = '0; m_stb = '0;
      ack_en = 1'b1; err_inj = 1'b0; force_ack = 1'b0;

      // Reset state
      step(); step(); settle();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_s_cyc", 32'(s_cyc), 32'h0);
      check("rst_s_stb", 32'(s_stb), 32'h0);
      check("rst_s_we",  32'(s_we),  32'h0);
      check("rst_m_ack", 32'(m_ack), 32'h0);
      check("rst_m_err", 32'(m_err), 32'h0);

      // Master 1 alone reads 0x100
      step(); rst = 1'b0; set_m(1, 1, 1, 0, 32'h100, 32'h0); settle();
      check("t1_idle_grant", 32'(grant), 32'h0);
      check("t1_idle_stb", 32'(s_stb), 32'h0);
      step(); settle();
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_s_stb", 32'(s_stb), 32'h1);
      check("t1_s_adr", s_adr, 32'h100);
      check("t1_ack_early", 32'(m_ack), 32'h0);
      step(); settle();
      check("t1_ack_wait", 32'(m_ack), 32'h0);
      step(); settle();
      check("t1_ack", 32'(m_ack), 32'h2);
      check("t1_rdata", m_rdat[63:32], 32'hDEAD_BEEF);
      step(); set_m(1, 0, 0, 0, 32'h0, 32'h0); settle();
      check("t1_drop_cyc", 32'(s_cyc), 32'h0);
      check("t1_drop_ack", 32'(m_ack), 32'h0);
      step(); settle();
      check("t1_idle_after", 32'(grant), 32'h0);

      // All three masters write back to back from reset
      rst = 1'b1;
      step(); step(); rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
         k = j % 3;
         r = j / 3;
         step();
         if (j == 0) begin
            for (int m = 0; m < 3; m++) set_m(m, 1, 1, 1, wadr(m, 0), wdat(m, 0));
         end else if (j - 1 < 3) begin
            set_m((j - 1) % 3, 1, 1, 1, wadr((j - 1) % 3, 1), wdat((j - 1) % 3, 1));
         end
         settle();
         check("t2_idle_grant", 32'(grant), 32'h0);
         step(); settle();
         check("t2_grant", 32'(grant), 32'(1 << k));
         check("t2_ack", 32'(m_ack), 32'(1 << k));
         check("t2_s_adr", s_adr, wadr(k, r));
         step(); set_m(k, 0, 0, 0, 32'h0, 32'h0); settle();
         check("t2_drop_cyc", 32'(s_cyc), 32'h0);
      end
      step(); settle();
      check("t2_end_idle", 32'(grant), 32'h0);
      for (int j = 0; j < 6; j++) begin
         check("t2_mem", mem[8'h80 + 8'(j)], wdat(j % 3, j / 3));
      end

      // Master 0 4-beat read burst while master 2 waits
      step(); set_m(0, 1, 1, 0, 32'h300, 32'h0); settle();
      check("t3_idle_grant", 32'(grant), 32'h0);
      for (int b = 0; b < 4; b++) begin
         step();
         set_m(0, 1, 1, 0, 32'h300 + 32'(4 * b), 32'h0);
         if (b == 0) set_m(2, 1, 1, 0, 32'h100, 32'h0);
         settle();
         check("t3_grant", 32'(grant), 32'h1);
         check("t3_s_adr", s_adr, 32'h300 + 32'(4 * b));
         step(); settle();
         check("t3_wait", 32'(m_ack), 32'h0);
         step(); settle();
         check("t3_ack", 32'(m_ack), 32'h1);
         check("t3_data", m_rdat[31:0], 32'h1111_0000 + 32'(b));
      end
      step(); set_m(0, 0, 0, 0, 32'h0, 32'h0); settle();
      check("t3_drop_grant", 32'(grant), 32'h1);
      check("t3_drop_cyc", 32'(s_cyc), 32'h0);
      step(); settle();
      check("t3_gap", 32'(grant), 32'h0);
      step(); settle();
      check("t3_m2_grant", 32'(grant), 32'h4);
      step(); settle();
      check("t3_m2_wait", 32'(m_ack), 32'h0);
      step(); settle();
      check("t3_m2_ack", 32'(m_ack), 32'h4);
      check("t3_m2_data", m_rdat[95:64], 32'hDEAD_BEEF);
      step(); set_m(2, 0, 0, 0, 32'h0, 32'h0); settle();
      step(); settle();
      check("t3_end_idle", 32'(grant), 32'h0);

      // Watchdog: slave never acks, TIMEOUT = 8
      step(); ack_en = 1'b0; set_m(2, 1, 1, 0, 32'h100, 32'h0); settle();
      check("t4_idle_grant", 32'(grant), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         step(); settle();
         check("t4_stb", 32'(s_stb), 32'h1);
         check("t4_err", 32'(m_err), (i == 8) ? 32'h4 : 32'h0);
      end
      step(); settle();
      check("t4_err_stb", 32'(s_stb), 32'h0);
      check("t4_err_cyc", 32'(s_cyc), 32'h0);
      check("t4_err_once", 32'(m_err), 32'h0);
      check("t4_err_grant", 32'(grant), 32'h4);
      step(); set_m(2, 0, 0, 0, 32'h0, 32'h0); settle();
      check("t4_drop_grant", 32'(grant), 32'h4);
      step(); settle();
      check("t4_back_idle", 32'(grant), 32'h0);

      // Ack arriving on the timeout cycle wins
      step(); set_m(2, 1, 1, 0, 32'h100, 32'h0); settle();
      for (int i = 1; i <= 7; i++) begin
         step(); settle();
      end
      step(); force_ack = 1'b1; settle();
      check("t4b_ack", 32'(m_ack), 32'h4);
      check("t4b_no_err", 32'(m_err), 32'h0);
      step(); force_ack = 1'b0; ack_en = 1'b1; settle();
      check("t4b_still_grant", 32'(s_stb), 32'h1);
      check("t4b_no_err2", 32'(m_err), 32'h0);
      step(); set_m(2, 0, 0, 0, 32'h0, 32'h0); settle();
      step(); settle();
      check("t4b_idle", 32'(grant), 32'h0);

      // Reset in the middle of a master-1 read
      step(); set_m(1, 1, 1, 0, 32'h100, 32'h0); settle();
      step(); settle();
      check("t5_s_stb", 32'(s_stb), 32'h1);
      check("t5_grant", 32'(grant), 32'h2);
      step(); rst = 1'b1; set_m(0, 1, 1, 1, 32'h380, 32'h5A5A_0001); settle();
      check("t5_no_ack_pre", 32'(m_ack), 32'h0);
      step(); rst = 1'b0; settle();
      check("t5_s_cyc", 32'(s_cyc), 32'h0);
      check("t5_s_stb_rst", 32'(s_stb), 32'h0);
      check("t5_no_ack", 32'(m_ack), 32'h0);
      check("t5_grant_rst", 32'(grant), 32'h0);
      step(); settle();
      check("t5_m0_wins", 32'(grant), 32'h1);
      check("t5_m0_ack", 32'(m_ack), 32'h1);
      step(); set_m(0, 0, 0, 0, 32'h0, 32'h0); set_m(1, 0, 0, 0, 32'h0, 32'h0); settle();
      step(); settle();
      check("t5_idle", 32'(grant), 32'h0);
      check("t5_mem", mem[8'hE0], 32'h5A5A_0001);

      // Slave err on a master-0 write
      step(); err_inj = 1'b1; set_m(0, 1, 1, 1, 32'h3C0, 32'hBAD0_0BAD); settle();
      check("t6_idle_grant", 32'(grant), 32'h0);
      step(); settle();
      check("t6_err", 32'(m_err), 32'h1);
      check("t6_no_ack", 32'(m_ack), 32'h0);
      check("t6_grant", 32'(grant), 32'h1);
      step(); err_inj = 1'b0; set_m(0, 1, 0, 1, 32'h3C0, 32'hBAD0_0BAD); settle();
      check("t6_hold_grant", 32'(grant), 32'h1);
      check("t6_hold_cyc", 32'(s_cyc), 32'h1);
      check("t6_hold_stb", 32'(s_stb), 32'h0);
      check("t6_err_once", 32'(m_err), 32'h0);
      step(); settle();
      check("t6_hold_grant2", 32'(grant), 32'h1);
      step(); set_m(0, 0, 0, 0, 32'h0, 32'h0); settle();
      check("t6_drop_cyc", 32'(s_cyc), 32'h0);
      step(); settle();
      check("t6_idle", 32'(grant), 32'h0);
      check("t6_mem_untouched", mem[8'hF0], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
